// File: rtl/wt_dcache_reuse_pred_if.sv
// Bundles the cache-side signals of the reuse predictor: lookup, line events, training status
// and statistics. The cache controller holds the master modport and the predictor the slave.
interface wt_dcache_reuse_pred_if #(
  parameter int unsigned SIG_WIDTH = 8,
  parameter int unsigned NUM_IDX   = 256
);
  localparam int unsigned IdxW = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1;

  logic                 flush_i;
  logic                 pred_req_i;
  logic [SIG_WIDTH-1:0] pred_sig_i;
  logic                 pred_valid_o;
  logic [1:0]           pred_result_o;
  logic                 fill_i;
  logic [IdxW-1:0]      fill_idx_i;
  logic [1:0]           fill_way_i;
  logic [SIG_WIDTH-1:0] fill_sig_i;
  logic                 hit_i;
  logic [IdxW-1:0]      hit_idx_i;
  logic [1:0]           hit_way_i;
  logic                 evict_i;
  logic [IdxW-1:0]      evict_idx_i;
  logic [1:0]           evict_way_i;
  logic                 train_drop_o;
  logic [31:0]          pred_dead_cnt_o;
  logic [31:0]          train_drop_cnt_o;

  modport master (
    output flush_i, pred_req_i, pred_sig_i,
    output fill_i, fill_idx_i, fill_way_i, fill_sig_i,
    output hit_i, hit_idx_i, hit_way_i,
    output evict_i, evict_idx_i, evict_way_i,
    input  pred_valid_o, pred_result_o, train_drop_o, pred_dead_cnt_o, train_drop_cnt_o
  );

  modport slave (
    input  flush_i, pred_req_i, pred_sig_i,
    input  fill_i, fill_idx_i, fill_way_i, fill_sig_i,
    input  hit_i, hit_idx_i, hit_way_i,
    input  evict_i, evict_idx_i, evict_way_i,
    output pred_valid_o, pred_result_o, train_drop_o, pred_dead_cnt_o, train_drop_cnt_o
  );
endinterface

// File: rtl/wt_dcache_reuse_pred.sv
// Signature-indexed dead-block predictor trained through a small update FIFO.
// Define WT_DCACHE_REUSE_PRED_STATS_EN to build the dead-prediction and drop statistic counters.
module wt_dcache_reuse_pred #(
  parameter int unsigned SIG_WIDTH  = 8,
  parameter int unsigned NUM_IDX    = 256,
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wt_dcache_reuse_pred_if.slave bus
);
  localparam int unsigned NumSig = 2 ** SIG_WIDTH;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;

  typedef struct packed {
    logic [SIG_WIDTH-1:0] sig;
    logic                 inc;
  } upd_t;

  logic [1:0]           r_ctr  [NumSig];
  logic [SIG_WIDTH-1:0] r_lsig [NUM_IDX][NUM_WAYS];
  logic                 r_lre  [NUM_IDX][NUM_WAYS];
  upd_t                 r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]      r_wptr, r_rptr;
  logic [CntW-1:0]      r_cnt;
  logic                 r_pred_valid;
  logic [1:0]           r_pred_result;
  logic                 r_train_drop;

  logic                 w_hit_fill_same;
  logic                 w_hit_set;
  logic                 w_hit_push, w_evict_push;
  logic                 w_hit_acc, w_evict_acc;
  logic [SIG_WIDTH-1:0] w_hit_sig, w_evict_sig;
  logic                 w_pop;
  upd_t                 w_pop_upd;
  logic [1:0]           w_pop_old, w_pop_new;
  logic [CntW-1:0]      w_free;
  logic [1:0]           w_n_acc, w_drop_n;
  logic [PtrW-1:0]      w_hit_ptr;
  logic [1:0]           w_lookup;

  // Training sources read registered line state, so a same-cycle fill never affects them.
  assign w_hit_fill_same = bus.fill_i && (bus.fill_idx_i == bus.hit_idx_i) &&
                           (bus.fill_way_i == bus.hit_way_i);
  assign w_hit_set       = bus.hit_i && !w_hit_fill_same;
  assign w_hit_push      = w_hit_set && !r_lre[bus.hit_idx_i][bus.hit_way_i];
  assign w_evict_push    = bus.evict_i && !r_lre[bus.evict_idx_i][bus.evict_way_i];
  assign w_hit_sig       = r_lsig[bus.hit_idx_i][bus.hit_way_i];
  assign w_evict_sig     = r_lsig[bus.evict_idx_i][bus.evict_way_i];

  assign w_pop     = (r_cnt != '0);
  assign w_pop_upd = r_fifo[r_rptr];
  assign w_pop_old = r_ctr[w_pop_upd.sig];

  always_comb begin
    w_pop_new = w_pop_old;
    if (w_pop_upd.inc) begin
      if (w_pop_old != 2'b11) w_pop_new = w_pop_old + 2'b01;
    end else begin
      if (w_pop_old != 2'b00) w_pop_new = w_pop_old - 2'b01;
    end
  end

  // The pop frees its slot before this cycle's pushes are admitted; evict claims first.
  assign w_free      = CntW'(FIFO_DEPTH) - r_cnt + CntW'(w_pop);
  assign w_evict_acc = w_evict_push && (w_free != '0);
  assign w_hit_acc   = w_hit_push && (w_free >= (w_evict_acc ? CntW'(2) : CntW'(1)));
  assign w_n_acc     = {1'b0, w_evict_acc} + {1'b0, w_hit_acc};
  assign w_drop_n    = {1'b0, w_evict_push && !w_evict_acc} + {1'b0, w_hit_push && !w_hit_acc};
  assign w_hit_ptr   = r_wptr + PtrW'(w_evict_acc);

  assign w_lookup = (w_pop && (w_pop_upd.sig == bus.pred_sig_i)) ? w_pop_new
                                                                  : r_ctr[bus.pred_sig_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumSig; i++) r_ctr[i] <= 2'b01;
    end else if (bus.flush_i) begin
      for (int unsigned i = 0; i < NumSig; i++) r_ctr[i] <= 2'b01;
    end else if (w_pop) begin
      r_ctr[w_pop_upd.sig] <= w_pop_new;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_IDX; i++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          r_lsig[i][w] <= '0;
          r_lre[i][w]  <= 1'b0;
        end
      end
    end else if (bus.flush_i) begin
      for (int unsigned i = 0; i < NUM_IDX; i++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          r_lsig[i][w] <= '0;
          r_lre[i][w]  <= 1'b0;
        end
      end
    end else begin
      if (w_hit_set) r_lre[bus.hit_idx_i][bus.hit_way_i] <= 1'b1;
      if (bus.fill_i) begin
        r_lsig[bus.fill_idx_i][bus.fill_way_i] <= bus.fill_sig_i;
        r_lre[bus.fill_idx_i][bus.fill_way_i]  <= 1'b0;
      end
    end
  end

  // Entry storage needs no reset: occupancy is tracked by r_cnt alone.
  always_ff @(posedge clk_i) begin
    if (!bus.flush_i) begin
      if (w_evict_acc) r_fifo[r_wptr]    <= '{sig: w_evict_sig, inc: 1'b1};
      if (w_hit_acc)   r_fifo[w_hit_ptr] <= '{sig: w_hit_sig, inc: 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (bus.flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_wptr <= r_wptr + PtrW'(w_n_acc);
      r_rptr <= r_rptr + PtrW'(w_pop);
      r_cnt  <= r_cnt - CntW'(w_pop) + CntW'(w_n_acc);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pred_valid  <= 1'b0;
      r_pred_result <= 2'b00;
      r_train_drop  <= 1'b0;
    end else if (bus.flush_i) begin
      r_pred_valid  <= 1'b0;
      r_pred_result <= 2'b00;
      r_train_drop  <= 1'b0;
    end else begin
      r_pred_valid <= bus.pred_req_i;
      if (bus.pred_req_i) r_pred_result <= w_lookup;
      r_train_drop <= (w_drop_n != 2'b00);
    end
  end

  assign bus.pred_valid_o  = r_pred_valid;
  assign bus.pred_result_o = r_pred_result;
  assign bus.train_drop_o  = r_train_drop;

`ifdef WT_DCACHE_REUSE_PRED_STATS_EN
  logic [31:0] r_dead_cnt, r_drop_cnt;

  // Dead count steps on the same edge that raises pred_valid_o, keeping both aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dead_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (bus.flush_i) begin
      r_dead_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (bus.pred_req_i && w_lookup[1]) r_dead_cnt <= r_dead_cnt + 32'd1;
      r_drop_cnt <= r_drop_cnt + 32'(w_drop_n);
    end
  end

  assign bus.pred_dead_cnt_o  = r_dead_cnt;
  assign bus.train_drop_cnt_o = r_drop_cnt;
`else
  assign bus.pred_dead_cnt_o  = '0;
  assign bus.train_drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wt_dcache_reuse_pred.sv
// Self-checking bench for wt_dcache_reuse_pred: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the predictor's rules.
module tb_wt_dcache_reuse_pred;
  localparam int unsigned SigW   = 8;
  localparam int unsigned NumIdx = 16;
  localparam int unsigned Depth  = 4;

  logic clk;
  logic rst_n;

  wt_dcache_reuse_pred_if #(.SIG_WIDTH(SigW), .NUM_IDX(NumIdx)) bus ();

  wt_dcache_reuse_pred #(
    .SIG_WIDTH (SigW),
    .NUM_IDX   (NumIdx),
    .NUM_WAYS  (4),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model state
  logic [1:0]  m_ctr  [256];
  logic [7:0]  m_lsig [NumIdx][4];
  logic        m_lre  [NumIdx][4];
  logic [8:0]  m_q    [$];
  logic        m_valid;
  logic [1:0]  m_result;
  logic        m_drop;
  logic [31:0] m_dead;
  logic [31:0] m_dropcnt;

  function automatic logic [31:0] exp_dead();
`ifdef WT_DCACHE_REUSE_PRED_STATS_EN
    return m_dead;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_dropcnt();
`ifdef WT_DCACHE_REUSE_PRED_STATS_EN
    return m_dropcnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_ctr[i] = 2'b01;
    for (int i = 0; i < NumIdx; i++) begin
      for (int w = 0; w < 4; w++) begin
        m_lsig[i][w] = 8'h00;
        m_lre[i][w]  = 1'b0;
      end
    end
    m_q.delete();
    m_valid   = 1'b0;
    m_result  = 2'b00;
    m_drop    = 1'b0;
    m_dead    = 32'd0;
    m_dropcnt = 32'd0;
  endtask

  // Applies one cycle of the predictor's rules to the currently driven inputs.
  task automatic model_eval();
    int         drops;
    logic       same, ev, hp;
    logic [7:0] e_sig, h_sig;
    logic [8:0] e;
    if (bus.flush_i) begin
      model_reset();
      return;
    end
    drops = 0;
    same  = bus.fill_i && (bus.fill_idx_i == bus.hit_idx_i) && (bus.fill_way_i == bus.hit_way_i);
    ev    = bus.evict_i && !m_lre[bus.evict_idx_i][bus.evict_way_i];
    hp    = bus.hit_i && !same && !m_lre[bus.hit_idx_i][bus.hit_way_i];
    e_sig = m_lsig[bus.evict_idx_i][bus.evict_way_i];
    h_sig = m_lsig[bus.hit_idx_i][bus.hit_way_i];
    if (m_q.size() > 0) begin
      e = m_q.pop_front();
      if (e[0]) begin
        if (m_ctr[e[8:1]] != 2'd3) m_ctr[e[8:1]] = m_ctr[e[8:1]] + 2'd1;
      end else begin
        if (m_ctr[e[8:1]] != 2'd0) m_ctr[e[8:1]] = m_ctr[e[8:1]] - 2'd1;
      end
    end
    m_valid = bus.pred_req_i;
    if (bus.pred_req_i) begin
      m_result = m_ctr[bus.pred_sig_i];
      if (m_result[1]) m_dead = m_dead + 32'd1;
    end
    if (ev) begin
      if (m_q.size() < Depth) m_q.push_back({e_sig, 1'b1});
      else drops++;
    end
    if (hp) begin
      if (m_q.size() < Depth) m_q.push_back({h_sig, 1'b0});
      else drops++;
    end
    m_drop    = (drops > 0);
    m_dropcnt = m_dropcnt + 32'(drops);
    if (bus.hit_i && !same) m_lre[bus.hit_idx_i][bus.hit_way_i] = 1'b1;
    if (bus.fill_i) begin
      m_lsig[bus.fill_idx_i][bus.fill_way_i] = bus.fill_sig_i;
      m_lre[bus.fill_idx_i][bus.fill_way_i]  = 1'b0;
    end
  endtask

  task automatic drive_idle();
    bus.flush_i     = 1'b0;
    bus.pred_req_i  = 1'b0;
    bus.pred_sig_i  = 8'h00;
    bus.fill_i      = 1'b0;
    bus.fill_idx_i  = 4'd0;
    bus.fill_way_i  = 2'd0;
    bus.fill_sig_i  = 8'h00;
    bus.hit_i       = 1'b0;
    bus.hit_idx_i   = 4'd0;
    bus.hit_way_i   = 2'd0;
    bus.evict_i     = 1'b0;
    bus.evict_idx_i = 4'd0;
    bus.evict_way_i = 2'd0;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic do_fill(input logic [3:0] idx, input logic [1:0] way, input logic [7:0] sig);
    bus.fill_i = 1'b1; bus.fill_idx_i = idx; bus.fill_way_i = way; bus.fill_sig_i = sig;
    step();
  endtask

  task automatic do_lookup(input logic [7:0] sig);
    bus.pred_req_i = 1'b1; bus.pred_sig_i = sig;
    step();
  endtask

  task automatic test_reset();
    total++;
    if (bus.pred_valid_o !== 1'b0 || bus.pred_result_o !== 2'b00 || bus.train_drop_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b result=%b drop=%b, required 0/00/0",
               bus.pred_valid_o, bus.pred_result_o, bus.train_drop_o);
    end
    total++;
    if (bus.pred_dead_cnt_o !== 32'd0 || bus.train_drop_cnt_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_stats: dead=%0d drop=%0d, required 0/0",
               bus.pred_dead_cnt_o, bus.train_drop_cnt_o);
    end
    do_lookup(8'h3A);
    total++;
    if (bus.pred_valid_o !== 1'b1 || bus.pred_result_o !== 2'b01) begin
      bad++;
      $display("FAIL reset_lookup: valid=%b result=%b, required 1/01",
               bus.pred_valid_o, bus.pred_result_o);
    end
    step();
    total++;
    if (bus.pred_valid_o !== 1'b0 || bus.pred_result_o !== 2'b01) begin
      bad++;
      $display("FAIL result_hold: valid=%b result=%b, required 0/01",
               bus.pred_valid_o, bus.pred_result_o);
    end
  endtask

  task automatic test_evict_sat();
    logic [1:0] want [4];
    want[0] = 2'b10; want[1] = 2'b11; want[2] = 2'b11; want[3] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      do_fill(4'd5, 2'd2, 8'h10);
      bus.evict_i = 1'b1; bus.evict_idx_i = 4'd5; bus.evict_way_i = 2'd2;
      step();
      do_lookup(8'h10);
      total++;
      if (bus.pred_result_o !== want[k] || bus.pred_result_o !== m_result) begin
        bad++;
        $display("FAIL evict_sat[%0d]: result=%b, required %b", k, bus.pred_result_o, want[k]);
      end
    end
    total++;
    if (bus.pred_dead_cnt_o !== exp_dead()) begin
      bad++;
      $display("FAIL dead_cnt: got %0d, required %0d", bus.pred_dead_cnt_o, exp_dead());
    end
  endtask

  task automatic test_hit_once();
    do_fill(4'd3, 2'd1, 8'h20);
    for (int k = 0; k < 3; k++) begin
      bus.hit_i = 1'b1; bus.hit_idx_i = 4'd3; bus.hit_way_i = 2'd1;
      step();
    end
    do_lookup(8'h20);
    total++;
    if (bus.pred_result_o !== 2'b00) begin
      bad++;
      $display("FAIL hit_single_dec: result=%b, required 00", bus.pred_result_o);
    end
    bus.evict_i = 1'b1; bus.evict_idx_i = 4'd3; bus.evict_way_i = 2'd1;
    step();
    step();
    do_lookup(8'h20);
    total++;
    if (bus.pred_result_o !== 2'b00) begin
      bad++;
      $display("FAIL reused_evict_no_inc: result=%b, required 00", bus.pred_result_o);
    end
  endtask

  task automatic test_forward();
    do_fill(4'd7, 2'd0, 8'h55);
    step();
    bus.evict_i = 1'b1; bus.evict_idx_i = 4'd7; bus.evict_way_i = 2'd0;
    step();
    do_lookup(8'h55);
    total++;
    if (bus.pred_valid_o !== 1'b1 || bus.pred_result_o !== 2'b10) begin
      bad++;
      $display("FAIL forward: valid=%b result=%b, required 1/10",
               bus.pred_valid_o, bus.pred_result_o);
    end
  endtask

  task automatic test_overflow();
    logic want [4];
    want[0] = 1'b0; want[1] = 1'b0; want[2] = 1'b0; want[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_fill(4'(8 + i), 2'd0, 8'(8'h60 + i));
      do_fill(4'(8 + i), 2'd1, 8'(8'h70 + i));
    end
    step();
    for (int k = 0; k < 4; k++) begin
      bus.hit_i   = 1'b1; bus.hit_idx_i   = 4'(8 + k); bus.hit_way_i   = 2'd0;
      bus.evict_i = 1'b1; bus.evict_idx_i = 4'(8 + k); bus.evict_way_i = 2'd1;
      step();
      total++;
      if (bus.train_drop_o !== want[k]) begin
        bad++;
        $display("FAIL overflow_drop[%0d]: drop=%b, required %b", k, bus.train_drop_o, want[k]);
      end
    end
    total++;
    if (bus.train_drop_cnt_o !== exp_dropcnt()) begin
      bad++;
      $display("FAIL drop_cnt: got %0d, required %0d", bus.train_drop_cnt_o, exp_dropcnt());
    end
  endtask

  task automatic test_flush();
    logic [7:0] sigs [5];
    sigs[0] = 8'h70; sigs[1] = 8'h71; sigs[2] = 8'h60; sigs[3] = 8'h10; sigs[4] = 8'h20;
    bus.flush_i = 1'b1; bus.pred_req_i = 1'b1; bus.pred_sig_i = 8'h10;
    step();
    total++;
    if (bus.pred_valid_o !== 1'b0 || bus.pred_result_o !== 2'b00 || bus.train_drop_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_outputs: valid=%b result=%b drop=%b, required 0/00/0",
               bus.pred_valid_o, bus.pred_result_o, bus.train_drop_o);
    end
    total++;
    if (bus.train_drop_cnt_o !== 32'd0 || bus.pred_dead_cnt_o !== 32'd0) begin
      bad++;
      $display("FAIL flush_stats: dead=%0d drop=%0d, required 0/0",
               bus.pred_dead_cnt_o, bus.train_drop_cnt_o);
    end
    for (int k = 0; k < 5; k++) begin
      do_lookup(sigs[k]);
      total++;
      if (bus.pred_result_o !== 2'b01) begin
        bad++;
        $display("FAIL flush_ctr[%02h]: result=%b, required 01", sigs[k], bus.pred_result_o);
      end
    end
  endtask

  task automatic test_async_reset();
    do_fill(4'd1, 2'd3, 8'h33);
    bus.evict_i = 1'b1; bus.evict_idx_i = 4'd1; bus.evict_way_i = 2'd3;
    bus.pred_req_i = 1'b1; bus.pred_sig_i = 8'h33;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.pred_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_valid: valid=%b, required 0", bus.pred_valid_o);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_lookup(8'h33);
    total++;
    if (bus.pred_result_o !== 2'b01) begin
      bad++;
      $display("FAIL async_reset_ctr: result=%b, required 01", bus.pred_result_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      bus.flush_i     = ($urandom_range(0, 99) == 0);
      bus.pred_req_i  = $urandom_range(0, 1) == 1;
      bus.pred_sig_i  = 8'($urandom_range(0, 7));
      bus.fill_i      = $urandom_range(0, 9) < 3;
      bus.fill_idx_i  = 4'($urandom_range(0, 3));
      bus.fill_way_i  = 2'($urandom_range(0, 3));
      bus.fill_sig_i  = 8'($urandom_range(0, 7));
      bus.hit_i       = $urandom_range(0, 9) < 4;
      bus.hit_idx_i   = 4'($urandom_range(0, 3));
      bus.hit_way_i   = 2'($urandom_range(0, 3));
      bus.evict_i     = $urandom_range(0, 9) < 4;
      bus.evict_idx_i = 4'($urandom_range(0, 3));
      bus.evict_way_i = 2'($urandom_range(0, 3));
      step();
      total++;
      if (bus.pred_valid_o !== m_valid || bus.pred_result_o !== m_result) begin
        bad++;
        $display("FAIL rand_pred[%0d]: valid=%b result=%b, required %b/%b",
                 n, bus.pred_valid_o, bus.pred_result_o, m_valid, m_result);
      end
      total++;
      if (bus.train_drop_o !== m_drop) begin
        bad++;
        $display("FAIL rand_drop[%0d]: drop=%b, required %b", n, bus.train_drop_o, m_drop);
      end
      total++;
      if (bus.pred_dead_cnt_o !== exp_dead() || bus.train_drop_cnt_o !== exp_dropcnt()) begin
        bad++;
        $display("FAIL rand_stats[%0d]: dead=%0d drop=%0d, required %0d/%0d", n,
                 bus.pred_dead_cnt_o, bus.train_drop_cnt_o, exp_dead(), exp_dropcnt());
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_evict_sat();
    test_hit_once();
    test_forward();
    test_overflow();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
